// File: rtl/mem0_dmem_ctrl_pkg.sv
// mem0_dmem_ctrl_pkg: shared op codes, transfer sizes, FSM states and op
// decode helpers for the MEM0 data-memory controller.
// Build option: MEM0_LWLR_EN enables the LWL/LWR/SWL/SWR merge ops.
package mem0_dmem_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8,
        MEM_LWL  = 4'd9,
        MEM_LWR  = 4'd10,
        MEM_SWL  = 4'd11,
        MEM_SWR  = 4'd12
    } mem_op_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } state_e;

    // Op codes that read memory; merge loads only exist when enabled.
    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW: op_is_load = 1'b1;
`ifdef MEM0_LWLR_EN
            MEM_LWL, MEM_LWR:                        op_is_load = 1'b1;
`endif
            default:                                 op_is_load = 1'b0;
        endcase
    endfunction

    // Op codes that write memory; merge stores only exist when enabled.
    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            MEM_SB, MEM_SH, MEM_SW: op_is_store = 1'b1;
`ifdef MEM0_LWLR_EN
            MEM_SWL, MEM_SWR:       op_is_store = 1'b1;
`endif
            default:                op_is_store = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem0_dmem_ctrl_mem_align.sv
// mem0_dmem_ctrl_mem_align: combinational lane alignment for the MEM0
// controller -- store strobes/data, transfer size, and load
// extract/extend/merge from a raw 32-bit word.
// Build option: MEM0_LWLR_EN adds the LWL/LWR/SWL/SWR merge paths;
// without it those codes produce zero strobes, data and load result.
module mem0_dmem_ctrl_mem_align
    import mem0_dmem_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rf_data,
    input  logic [31:0] raw_word,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [4:0]  sh_amt;
    logic [31:0] shifted;

    assign sh_amt  = {addr_lo, 3'b000};
    assign shifted = raw_word >> sh_amt;

`ifdef MEM0_LWLR_EN
    localparam logic [31:0] ONES = '1;
    logic [4:0] inv_amt;
    // ~addr_lo == 3 - addr_lo, so this is 8*(3-k) for the left-merge ops
    assign inv_amt = {~addr_lo, 3'b000};
`endif

    // Per-op size, store lane placement and load result
    always_comb begin
        size    = SIZE_BYTE;
        wstrb   = '0;
        wdata   = '0;
        ld_data = '0;
        case (op)
            MEM_LB: begin
                size    = SIZE_BYTE;
                ld_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            MEM_LBU: begin
                size    = SIZE_BYTE;
                ld_data = {24'd0, shifted[7:0]};
            end
            MEM_LH: begin
                size    = SIZE_HALF;
                ld_data = {{16{shifted[15]}}, shifted[15:0]};
            end
            MEM_LHU: begin
                size    = SIZE_HALF;
                ld_data = {16'd0, shifted[15:0]};
            end
            MEM_LW: begin
                size    = SIZE_WORD;
                ld_data = shifted;
            end
            MEM_SB: begin
                size  = SIZE_BYTE;
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{rf_data[7:0]}};
            end
            MEM_SH: begin
                size  = SIZE_HALF;
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rf_data[15:0]}};
            end
            MEM_SW: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111;
                wdata = rf_data;
            end
`ifdef MEM0_LWLR_EN
            MEM_LWL: begin
                size    = SIZE_WORD;
                ld_data = (raw_word << inv_amt) | (rf_data & ~(ONES << inv_amt));
            end
            MEM_LWR: begin
                size    = SIZE_WORD;
                ld_data = (raw_word >> sh_amt) | (rf_data & ~(ONES >> sh_amt));
            end
            MEM_SWL: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111 >> ~addr_lo;
                wdata = rf_data >> inv_amt;
            end
            MEM_SWR: begin
                size  = SIZE_WORD;
                wstrb = 4'b1111 << addr_lo;
                wdata = rf_data << sh_amt;
            end
`endif
            default: begin
                size = SIZE_BYTE;
            end
        endcase
    end

endmodule

// File: rtl/mem0_dmem_ctrl.sv
// mem0_dmem_ctrl: MEM0-stage data-memory access controller.
// Turns one MEM0 load/store into a single request/response transaction,
// generates ready_go/stall_out, and holds load data until MEM1 accepts it.
// Build option: MEM0_LWLR_EN enables LWL/LWR/SWL/SWR (see package/align).
// DATA_W is fixed at 32.
module mem0_dmem_ctrl
    import mem0_dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [3:0]        mem_op,
    input  logic              exc_in,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              uncached,
    input  logic              mem1_allow,
    output logic              req,
    output logic              req_wr,
    output logic [1:0]        req_size,
    output logic [ADDR_W-1:0] req_addr,
    output logic [3:0]        req_wstrb,
    output logic [DATA_W-1:0] req_wdata,
    output logic              req_cached,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata,
    output logic              ready_go,
    output logic              stall_out,
    output logic [DATA_W-1:0] ld_data
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ld_buf_q;
    logic [DATA_W-1:0] raw_word;
    logic              is_store;
    logic              issue;
    logic              use_rdata;
    logic [1:0]        align_size;
    logic [3:0]        align_wstrb;

    assign is_store = op_is_store(mem_op);
    assign issue    = valid_in & (op_is_load(mem_op) | is_store) & ~exc_in & ~flush;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Load buffer: captures the response when MEM1 cannot take it yet and
    // is cleared on leaving DONE so an old word never resurfaces
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_buf_q <= '0;
        end else if (state_q == ST_WAIT && data_ok && !flush && !mem1_allow) begin
            ld_buf_q <= rdata;
        end else if (state_q == ST_DONE && (flush || mem1_allow)) begin
            ld_buf_q <= '0;
        end
    end

    // Next-state logic for the single-outstanding transaction
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) state_d = addr_ok ? ST_WAIT : ST_REQ;
            end
            ST_REQ: begin
                if (flush)        state_d = ST_IDLE;
                else if (addr_ok) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (data_ok)    state_d = (flush || mem1_allow) ? ST_IDLE : ST_DONE;
                else if (flush) state_d = ST_DRAIN;
            end
            ST_DONE: begin
                if (flush || mem1_allow) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs per state: request valid, pipeline advance, response select
    always_comb begin
        req       = 1'b0;
        ready_go  = 1'b0;
        use_rdata = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req      = issue;
                ready_go = ~issue;
            end
            ST_REQ: begin
                // a flush withdraws the not-yet-accepted request
                req = ~flush;
            end
            ST_WAIT: begin
                ready_go  = data_ok;
                use_rdata = data_ok & ~flush;
            end
            ST_DONE: begin
                ready_go = 1'b1;
            end
            default: begin
                req = 1'b0;
            end
        endcase
    end

    assign raw_word = use_rdata ? rdata : ld_buf_q;

    mem0_dmem_ctrl_mem_align u_mem_align (
        .op       (mem_op),
        .addr_lo  (paddr[1:0]),
        .rf_data  (rf_data),
        .raw_word (raw_word),
        .size     (align_size),
        .wstrb    (align_wstrb),
        .wdata    (req_wdata),
        .ld_data  (ld_data)
    );

    assign req_size   = align_size;
    assign req_wr     = req & is_store;
    assign req_wstrb  = req ? align_wstrb : '0;
    assign req_addr   = (align_size == SIZE_WORD) ? {paddr[ADDR_W-1:2], 2'b00} : paddr;
    assign req_cached = ~uncached;
    assign stall_out  = valid_in & ~ready_go;

endmodule

// File: tb/tb_mem0_dmem_ctrl.sv
// tb_mem0_dmem_ctrl: self-checking bench for mem0_dmem_ctrl. Acts as the
// memory bridge and MEM1 stage, drives directed and random operations and
// compares against a byte-level reference model.
// Build option: MEM0_LWLR_EN selects the merge-op expectations.
module tb_mem0_dmem_ctrl;

`ifdef MEM0_LWLR_EN
    localparam bit LWLR = 1'b1;
`else
    localparam bit LWLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, flush, valid_in, exc_in, uncached, mem1_allow;
    logic        addr_ok, data_ok;
    logic [3:0]  mem_op;
    logic [31:0] paddr, rf_data, rdata;
    logic        req, req_wr, req_cached, ready_go, stall_out;
    logic [1:0]  req_size;
    logic [3:0]  req_wstrb;
    logic [31:0] req_addr, req_wdata, ld_data;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    mem0_dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .valid_in   (valid_in),
        .mem_op     (mem_op),
        .exc_in     (exc_in),
        .paddr      (paddr),
        .rf_data    (rf_data),
        .uncached   (uncached),
        .mem1_allow (mem1_allow),
        .req        (req),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wstrb  (req_wstrb),
        .req_wdata  (req_wdata),
        .req_cached (req_cached),
        .addr_ok    (addr_ok),
        .data_ok    (data_ok),
        .rdata      (rdata),
        .ready_go   (ready_go),
        .stall_out  (stall_out),
        .ld_data    (ld_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_is_load(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd5) || (LWLR && (op == 4'd9 || op == 4'd10));
    endfunction

    function automatic logic m_is_store(input logic [3:0] op);
        return (op >= 4'd6 && op <= 4'd8) || (LWLR && (op == 4'd11 || op == 4'd12));
    endfunction

    function automatic logic [31:0] m_size(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2 || op == 4'd6) return 32'd0;
        if (op == 4'd3 || op == 4'd4 || op == 4'd7) return 32'd1;
        return 32'd2;
    endfunction

    function automatic logic [31:0] m_addr(input logic [3:0] op, input logic [31:0] a);
        if (m_size(op) == 32'd2) return a & 32'hFFFF_FFFC;
        return a;
    endfunction

    function automatic logic [31:0] m_strb(input logic [3:0] op, input logic [31:0] a);
        int k;
        k = int'(a % 4);
        case (op)
            4'd6:    return 32'd1 << k;
            4'd7:    return (k >= 2) ? 32'd12 : 32'd3;
            4'd8:    return 32'd15;
            4'd11:   return (32'd2 << k) - 32'd1;
            4'd12:   return (32'd15 << k) & 32'd15;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rf);
        int k;
        k = int'(a % 4);
        case (op)
            4'd6:    return (rf & 32'hFF) * 32'h0101_0101;
            4'd7:    return (rf & 32'hFFFF) * 32'h0001_0001;
            4'd8:    return rf;
            4'd11:   return rf >> (8 * (3 - k));
            4'd12:   return rf << (8 * k);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_ld(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] rf, input logic [31:0] w);
        logic [7:0]  b [4];
        logic [7:0]  r [4];
        logic [31:0] v;
        int k;
        k = int'(a % 4);
        for (int i = 0; i < 4; i++) begin
            b[i] = w[8*i +: 8];
            r[i] = rf[8*i +: 8];
        end
        v = 32'd0;
        case (op)
            4'd1: begin
                v = 32'(b[k]);
                if (v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            4'd2: v = 32'(b[k]);
            4'd3: begin
                v = 32'(b[k]) + 32'(b[(k + 1) % 4]) * 32'd256;
                if (v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            4'd4: v = 32'(b[k]) + 32'(b[(k + 1) % 4]) * 32'd256;
            4'd5: v = w;
            4'd9: begin
                for (int i = 0; i < 4; i++)
                    if (i >= 3 - k) r[i] = b[i - (3 - k)];
                v = {r[3], r[2], r[1], r[0]};
            end
            4'd10: begin
                for (int i = 0; i < 4; i++)
                    if (i <= 3 - k) r[i] = b[i + k];
                v = {r[3], r[2], r[1], r[0]};
            end
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic chk_req(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] rf, input logic unc);
        check({tag, "_req"}, 32'(req), 32'd1);
        check({tag, "_wr"}, 32'(req_wr), 32'(m_is_store(op)));
        check({tag, "_size"}, 32'(req_size), m_size(op));
        check({tag, "_addr"}, req_addr, m_addr(op, a));
        check({tag, "_strb"}, 32'(req_wstrb), m_strb(op, a));
        if (m_is_store(op)) check({tag, "_wdata"}, req_wdata, m_wdata(op, a, rf));
        check({tag, "_cached"}, 32'(req_cached), 32'(!unc));
        check({tag, "_stall"}, 32'(stall_out), 32'd1);
    endtask

    // One complete access: ad cycles of addr_ok low, data_ok dd cycles after
    // acceptance, then al extra cycles before MEM1 accepts.
    task automatic do_access(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] rf, input logic unc, input logic [31:0] w,
                             input int ad, input int dd, input int al);
        logic [31:0] exp_ld;
        exp_ld = m_is_load(op) ? m_ld(op, a, rf, w) : 32'd0;
        valid_in = 1'b1; mem_op = op; paddr = a; rf_data = rf; uncached = unc;
        exc_in = 1'b0; flush = 1'b0; mem1_allow = 1'b0; data_ok = 1'b0;
        for (int c = 0; c <= ad; c++) begin
            addr_ok = (c == ad);
            @(negedge clk);
            chk_req(tag, op, a, rf, unc);
            step();
        end
        addr_ok = 1'b0;
        for (int c = 1; c < dd; c++) begin
            @(negedge clk);
            check({tag, "_wait_req"}, 32'(req), 32'd0);
            check({tag, "_wait_stall"}, 32'(stall_out), 32'd1);
            step();
        end
        data_ok = 1'b1; rdata = w; mem1_allow = (al == 0);
        @(negedge clk);
        check({tag, "_data_rdy"}, 32'(ready_go), 32'd1);
        check({tag, "_data_ld"}, ld_data, exp_ld);
        step();
        data_ok = 1'b0; rdata = $urandom;
        for (int c = 1; c <= al; c++) begin
            mem1_allow = (c == al);
            @(negedge clk);
            check({tag, "_hold_rdy"}, 32'(ready_go), 32'd1);
            check({tag, "_hold_ld"}, ld_data, exp_ld);
            step();
        end
        valid_in = 1'b0; mem_op = 4'd0; mem1_allow = 1'b1;
        @(negedge clk);
        check({tag, "_end_req"}, 32'(req), 32'd0);
        check({tag, "_end_rdy"}, 32'(ready_go), 32'd1);
        step();
    endtask

    // An op that must not touch memory (no op, exception, unsupported code).
    task automatic no_access(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] rf, input logic exc);
        valid_in = 1'b1; mem_op = op; paddr = a; rf_data = rf; exc_in = exc;
        addr_ok = 1'b0; data_ok = 1'b0; mem1_allow = 1'b1; flush = 1'b0;
        @(negedge clk);
        check({tag, "_req"}, 32'(req), 32'd0);
        check({tag, "_rdy"}, 32'(ready_go), 32'd1);
        check({tag, "_stall"}, 32'(stall_out), 32'd0);
        if (!m_is_load(op)) check({tag, "_ld"}, ld_data, 32'd0);
        step();
        valid_in = 1'b0; exc_in = 1'b0; mem_op = 4'd0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; mem_op = 4'd0; exc_in = 1'b0;
        paddr = '0; rf_data = '0; uncached = 1'b0; mem1_allow = 1'b1;
        addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
        step(); step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(req), 32'd0);
        check("rst_wr", 32'(req_wr), 32'd0);
        check("rst_strb", 32'(req_wstrb), 32'd0);
        check("rst_rdy", 32'(ready_go), 32'd1);
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        step();

        // directed alignment cases
        do_access("lb", 4'd1, 32'h0000_1003, 32'h0, 1'b0, 32'h8011_2233, 0, 1, 0);
        do_access("lbu", 4'd2, 32'h0000_1003, 32'h0, 1'b0, 32'h8011_2233, 0, 1, 0);
        do_access("sh", 4'd7, 32'h0000_2002, 32'h0000_BEEF, 1'b1, 32'h0, 0, 1, 0);
        do_access("lw_slow", 4'd5, 32'h0000_3004, 32'h0, 1'b0, 32'hCAFE_F00D, 3, 2, 0);
        do_access("lw_done", 4'd5, 32'h0000_3008, 32'h0, 1'b0, 32'h1234_5678, 0, 1, 2);
        do_access("sw_done", 4'd8, 32'h0000_300C, 32'h5555_AAAA, 1'b0, 32'h0, 1, 1, 1);
        no_access("exc_lw", 4'd5, 32'h0000_4000, 32'h0, 1'b1);
        no_access("none", 4'd0, 32'h0000_4000, 32'h0, 1'b0);
`ifdef MEM0_LWLR_EN
        do_access("lwl", 4'd9, 32'h0000_5001, 32'h1122_3344, 1'b0, 32'hAABB_CCDD, 0, 1, 0);
`else
        no_access("lwl_off", 4'd9, 32'h0000_5001, 32'h1122_3344, 1'b0);
        no_access("swr_off", 4'd12, 32'h0000_5002, 32'h1122_3344, 1'b0);
`endif

        // flush while waiting: late response drained, new LW held off
        valid_in = 1'b1; mem_op = 4'd5; paddr = 32'h0000_6000; addr_ok = 1'b1; mem1_allow = 1'b1;
        @(negedge clk);
        check("fl_req", 32'(req), 32'd1);
        step();
        addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fl_wait_req", 32'(req), 32'd0);
        step();
        flush = 1'b0; paddr = 32'h0000_6010;
        @(negedge clk);
        check("drain_noreq", 32'(req), 32'd0);
        check("drain_stall", 32'(stall_out), 32'd1);
        step();
        data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("drain_noreq2", 32'(req), 32'd0);
        check("drain_stall2", 32'(stall_out), 32'd1);
        check("drain_stale", 32'(ld_data == 32'hDEAD_BEEF), 32'd0);
        step();
        data_ok = 1'b0; addr_ok = 1'b1;
        @(negedge clk);
        check("post_drain_req", 32'(req), 32'd1);
        check("post_drain_addr", req_addr, 32'h0000_6010);
        step();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("post_drain_rdy", 32'(ready_go), 32'd1);
        check("post_drain_ld", ld_data, 32'h0BAD_F00D);
        step();
        data_ok = 1'b0; valid_in = 1'b0;

        // flush in REQ drops the request
        valid_in = 1'b1; mem_op = 4'd8; paddr = 32'h0000_7000;
        @(negedge clk);
        check("flreq_req", 32'(req), 32'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("flreq_idle_req", 32'(req), 32'd0);
        check("flreq_idle_rdy", 32'(ready_go), 32'd1);
        step();

        // flush together with data_ok: data dropped, straight back to IDLE
        valid_in = 1'b1; mem_op = 4'd5; paddr = 32'h0000_7100; addr_ok = 1'b1;
        step();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h7777_7777; flush = 1'b1;
        step();
        data_ok = 1'b0; flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("fldata_rdy", 32'(ready_go), 32'd1);
        check("fldata_req", 32'(req), 32'd0);
        step();

        // flush in DONE
        valid_in = 1'b1; mem_op = 4'd5; paddr = 32'h0000_7200; addr_ok = 1'b1; mem1_allow = 1'b0;
        step();
        addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1357_9BDF;
        step();
        data_ok = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; valid_in = 1'b0; mem1_allow = 1'b1;
        @(negedge clk);
        check("fldone_rdy", 32'(ready_go), 32'd1);
        step();

        // reset mid-transaction: no drain afterwards
        valid_in = 1'b1; mem_op = 4'd5; paddr = 32'h0000_7300; addr_ok = 1'b1;
        step();
        addr_ok = 1'b0; valid_in = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rstmid_rdy", 32'(ready_go), 32'd1);
        check("rstmid_req", 32'(req), 32'd0);
        step();
        do_access("after_rst", 4'd3, 32'h0000_7402, 32'h0, 1'b0, 32'h8001_0002, 0, 1, 0);

        // randomized operations
        for (int n = 0; n < 160; n++) begin
            logic [3:0]  op;
            logic [31:0] a, rf, w;
            logic        unc, exc;
            int          ad, dd, al;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            rf  = $urandom;
            w   = $urandom;
            unc = 1'($urandom_range(0, 1));
            exc = ($urandom_range(0, 7) == 0);
            if (op == 4'd3 || op == 4'd4 || op == 4'd7) a[0] = 1'b0;
            if (op == 4'd5 || op == 4'd8) a[1:0] = 2'b00;
            ad = $urandom_range(0, 3);
            dd = $urandom_range(1, 3);
            al = $urandom_range(0, 2);
            if ((m_is_load(op) || m_is_store(op)) && !exc)
                do_access("rnd", op, a, rf, unc, w, ad, dd, al);
            else
                no_access("rnd_na", op, a, rf, exc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
